// File: rtl/eq_ui_pkg.sv
// Shared types and defaults for the equalizer user-interface controller.
package eq_ui_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LEVEL = 3'd1,
    ST_BAND  = 3'd2,
    ST_GAIN  = 3'd3
  } ui_state_t;

  localparam int NUM_BANDS_DEF = 6;
  localparam int GAIN_MAX_DEF  = 12;
  localparam int GAIN_MIN_DEF  = -12;

  typedef struct packed {
    logic [2:0]        band;
    logic signed [4:0] gain;
  } cfg_word_t;

endpackage

// File: rtl/ui_timeout_counter.sv
// Idle timer: counts while enabled, pulses tc on the last cycle and restarts.
module ui_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 250_000_000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = enable && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/eq_ui_controller.sv
// Key-driven UI state machine for the 6-band EQ: band/gain selection,
// display outputs and gain configuration words towards the filter datapath.
module eq_ui_controller
  import eq_ui_pkg::*;
#(
  parameter int          NUM_BANDS   = NUM_BANDS_DEF,
  parameter int          GAIN_MAX    = GAIN_MAX_DEF,
  parameter int          GAIN_MIN    = GAIN_MIN_DEF,
  parameter int unsigned TIMEOUT_CYC = 250_000_000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_mode,
  input  logic        i_key_up,
  input  logic        i_key_down,
  output logic [2:0]  o_state,
  output logic [2:0]  o_band,
  output logic [15:0] o_gain,
  output logic        o_cfg_valid,
  output logic [2:0]  o_cfg_band,
  output logic [4:0]  o_cfg_gain,
  input  logic        i_cfg_ready
);

  localparam logic [2:0]        LAST_BAND = 3'(NUM_BANDS);
  localparam logic signed [4:0] G_MAX     = 5'(GAIN_MAX);
  localparam logic signed [4:0] G_MIN     = 5'(GAIN_MIN);

  ui_state_t         state, state_nxt;
  logic [2:0]        band, band_nxt;
  logic signed [4:0] gains [NUM_BANDS];
  logic signed [4:0] gain_cur, gain_nxt, gain_disp;
  logic              gain_we;
  cfg_word_t         cfg, cfg_nxt;
  logic              cfg_valid, cfg_valid_nxt;
  logic              key_mode, key_up, key_down, any_key;
  logic              cnt_en, tc;

  assign key_mode = i_key_mode;
  assign key_up   = i_key_up & ~i_key_mode;
  assign key_down = i_key_down & ~i_key_up & ~i_key_mode;
  assign any_key  = i_key_mode | i_key_up | i_key_down;
  assign cnt_en   = (state == ST_BAND) || (state == ST_GAIN);
  assign gain_cur = gains[band - 3'd1];

  ui_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timeout (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (any_key),
    .enable(cnt_en),
    .tc    (tc)
  );

  always_comb begin
    state_nxt     = state;
    band_nxt      = band;
    gain_we       = 1'b0;
    gain_nxt      = gain_cur;
    cfg_nxt       = cfg;
    cfg_valid_nxt = cfg_valid;
    if (state == ST_INIT) begin
      // Broadcast: cfg.band walks 1..LAST_BAND with gain 0, one per accept.
      if (!cfg_valid) begin
        cfg_valid_nxt = 1'b1;
      end else if (i_cfg_ready) begin
        if (cfg.band == LAST_BAND) begin
          cfg_valid_nxt = 1'b0;
          state_nxt     = ST_LEVEL;
        end else begin
          cfg_nxt.band = cfg.band + 3'd1;
        end
      end
    end else begin
      if (cfg_valid && i_cfg_ready) cfg_valid_nxt = 1'b0;
      case (state)
        ST_LEVEL: if (key_mode) state_nxt = ST_LEVEL == state ? ST_BAND : state;
        ST_BAND: begin
          if (key_mode)      state_nxt = ST_GAIN;
          else if (key_up)   band_nxt  = (band == LAST_BAND) ? 3'd1 : band + 3'd1;
          else if (key_down) band_nxt  = (band == 3'd1) ? LAST_BAND : band - 3'd1;
          else if (tc)       state_nxt = ST_LEVEL;
        end
        ST_GAIN: begin
          if (key_mode) begin
            state_nxt = ST_BAND;
          end else if (key_up || key_down) begin
            if (!cfg_valid) begin
              if (key_up && (gain_cur < G_MAX)) begin
                gain_we  = 1'b1;
                gain_nxt = gain_cur + 5'sd1;
              end else if (key_down && (gain_cur > G_MIN)) begin
                gain_we  = 1'b1;
                gain_nxt = gain_cur - 5'sd1;
              end
            end
          end else if (tc) begin
            state_nxt = ST_LEVEL;
          end
        end
        default: ;
      endcase
      if (gain_we) begin
        cfg_nxt.band  = band;
        cfg_nxt.gain  = gain_nxt;
        cfg_valid_nxt = 1'b1;
      end
    end
  end

  assign gain_disp = gain_we ? gain_nxt : gains[band_nxt - 3'd1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_INIT;
      band      <= 3'd1;
      for (int unsigned i = 0; i < unsigned'(NUM_BANDS); i++) gains[i] <= '0;
      cfg.band  <= 3'd1;
      cfg.gain  <= '0;
      cfg_valid <= 1'b0;
      o_gain    <= '0;
    end else begin
      state     <= state_nxt;
      band      <= band_nxt;
      if (gain_we) gains[band - 3'd1] <= gain_nxt;
      cfg       <= cfg_nxt;
      cfg_valid <= cfg_valid_nxt;
      o_gain    <= {{11{gain_disp[4]}}, gain_disp};
    end
  end

  assign o_state     = state;
  assign o_band      = band;
  assign o_cfg_valid = cfg_valid;
  assign o_cfg_band  = cfg.band;
  assign o_cfg_gain  = cfg.gain;

endmodule

// File: tb/tb_eq_ui_controller.sv
// Scoreboard bench for eq_ui_controller: directed key/ready stimulus, monitor checks cfg words.
module tb_eq_ui_controller;

  logic        clk = 1'b0;
  logic        i_rst_n, i_key_mode, i_key_up, i_key_down, i_cfg_ready;
  logic [2:0]  o_state, o_band, o_cfg_band;
  logic [15:0] o_gain;
  logic        o_cfg_valid;
  logic [4:0]  o_cfg_gain;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  eq_ui_controller #(
    .TIMEOUT_CYC(16),
    .CNT_W      (5)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_key_mode (i_key_mode),
    .i_key_up   (i_key_up),
    .i_key_down (i_key_down),
    .o_state    (o_state),
    .o_band     (o_band),
    .o_gain     (o_gain),
    .o_cfg_valid(o_cfg_valid),
    .o_cfg_band (o_cfg_band),
    .o_cfg_gain (o_cfg_gain),
    .i_cfg_ready(i_cfg_ready)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input int b, input int g);
    exp_q.push_back({3'(b), 5'(g)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    i_key_mode = m;
    i_key_up   = u;
    i_key_down = d;
    tick(1);
    i_key_mode = 1'b0;
    i_key_up   = 1'b0;
    i_key_down = 1'b0;
  endtask

  // Monitor: handshake and hold checks sampled mid-cycle.
  logic [7:0] mon_exp;
  logic [7:0] held;
  logic       stall_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (stall_prev && i_rst_n === 1'b1)
        check("cfg_hold", {7'h0, o_cfg_valid, o_cfg_band, o_cfg_gain}, {7'h0, 1'b1, held});
      if (i_rst_n === 1'b1 && o_cfg_valid === 1'b1 && i_cfg_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cfg_unexpected: got %h expected none", {o_cfg_band, o_cfg_gain});
        end else begin
          mon_exp = exp_q.pop_front();
          check("cfg_word", {8'h0, o_cfg_band, o_cfg_gain}, {8'h0, mon_exp});
        end
      end
      stall_prev = (i_rst_n === 1'b1) && (o_cfg_valid === 1'b1) && (i_cfg_ready === 1'b0);
      held       = {o_cfg_band, o_cfg_gain};
    end
  end

  initial begin
    int n;
    i_rst_n = 1'b0; i_key_mode = 1'b0; i_key_up = 1'b0; i_key_down = 1'b0;
    i_cfg_ready = 1'b1;
    tick(2);
    check("rst_state", 16'(o_state), 16'd0);
    check("rst_band", 16'(o_band), 16'd1);
    check("rst_gain", o_gain, 16'd0);
    check("rst_valid", 16'(o_cfg_valid), 16'd0);
    check("rst_cfg_band", 16'(o_cfg_band), 16'd1);
    check("rst_cfg_gain", 16'(o_cfg_gain), 16'd0);

    // INIT broadcast with ready held high
    for (int b = 1; b <= 6; b++) push_word(b, 0);
    i_rst_n = 1'b1;
    tick(6);
    check("init_mid_state", 16'(o_state), 16'd0);
    check("init_last_band", 16'(o_cfg_band), 16'd6);
    tick(1);
    check("init_level", 16'(o_state), 16'd1);
    check("init_valid_low", 16'(o_cfg_valid), 16'd0);
    check("init_drain", 16'(exp_q.size()), 16'd0);

    // INIT broadcast with ready toggling
    i_rst_n = 1'b0;
    tick(1);
    i_rst_n = 1'b1;
    for (int b = 1; b <= 6; b++) push_word(b, 0);
    n = 0;
    while (o_state !== 3'd1 && n < 60) begin
      i_cfg_ready = ~i_cfg_ready;
      tick(1);
      n++;
    end
    check("init_toggle_level", 16'(o_state), 16'd1);
    check("init_toggle_drain", 16'(exp_q.size()), 16'd0);
    i_cfg_ready = 1'b1;

    // LEVEL ignores up, mode enters BAND, down wraps
    press(0, 1, 0);
    check("level_up_state", 16'(o_state), 16'd1);
    check("level_up_band", 16'(o_band), 16'd1);
    press(1, 0, 0);
    check("band_state", 16'(o_state), 16'd2);
    press(0, 0, 1);
    check("band_wrap_down", 16'(o_band), 16'd6);
    press(0, 0, 1);
    check("band_down", 16'(o_band), 16'd5);
    press(0, 0, 1);
    press(0, 0, 1);
    check("band_three", 16'(o_band), 16'd3);
    press(1, 0, 0);
    check("gain_state", 16'(o_state), 16'd3);

    // Saturating up sweep
    for (int i = 1; i <= 13; i++) begin
      if (i <= 12) push_word(3, i);
      press(0, 1, 0);
      tick(1);
    end
    check("gain_max", o_gain, 16'h000C);
    check("gain_max_drain", 16'(exp_q.size()), 16'd0);
    check("gain_max_valid", 16'(o_cfg_valid), 16'd0);

    // Saturating down sweep
    for (int i = 1; i <= 25; i++) begin
      if (i <= 24) push_word(3, 12 - i);
      press(0, 0, 1);
      tick(1);
    end
    check("gain_min", o_gain, 16'hFFF4);
    check("gain_min_drain", 16'(exp_q.size()), 16'd0);

    // Backpressure: ups ignored while stalled, mode honoured, word completes
    i_cfg_ready = 1'b0;
    push_word(3, -11);
    press(0, 1, 0);
    check("bp_gain", o_gain, 16'hFFF5);
    press(0, 1, 0);
    press(0, 1, 0);
    check("bp_gain_held", o_gain, 16'hFFF5);
    press(1, 0, 0);
    check("bp_mode_state", 16'(o_state), 16'd2);
    tick(3);
    check("bp_valid", 16'(o_cfg_valid), 16'd1);
    check("bp_cfg_band", 16'(o_cfg_band), 16'd3);
    check("bp_cfg_gain", 16'(o_cfg_gain), 16'h0015);
    i_cfg_ready = 1'b1;
    tick(1);
    check("bp_done_valid", 16'(o_cfg_valid), 16'd0);
    check("bp_drain", 16'(exp_q.size()), 16'd0);
    check("bp_band_gain", o_gain, 16'hFFF5);

    // Simultaneous mode+up, then timeout and key-at-terminal-count
    press(1, 1, 0);
    check("prio_state", 16'(o_state), 16'd3);
    check("prio_band", 16'(o_band), 16'd3);
    press(1, 0, 0);
    check("back_band", 16'(o_state), 16'd2);
    tick(15);
    check("to_before", 16'(o_state), 16'd2);
    tick(1);
    check("to_level", 16'(o_state), 16'd1);
    press(1, 0, 0);
    tick(15);
    press(0, 0, 1);
    check("to_key_state", 16'(o_state), 16'd2);
    check("to_key_band", 16'(o_band), 16'd2);
    tick(15);
    check("to_restart_before", 16'(o_state), 16'd2);
    tick(1);
    check("to_restart_level", 16'(o_state), 16'd1);

    // Reset during a stalled word
    press(1, 0, 0);
    press(1, 0, 0);
    i_cfg_ready = 1'b0;
    press(0, 1, 0);
    tick(2);
    check("stall_valid", 16'(o_cfg_valid), 16'd1);
    i_rst_n = 1'b0;
    tick(1);
    check("mid_rst_valid", 16'(o_cfg_valid), 16'd0);
    check("mid_rst_state", 16'(o_state), 16'd0);
    check("mid_rst_band", 16'(o_band), 16'd1);
    check("mid_rst_cfg_band", 16'(o_cfg_band), 16'd1);
    i_rst_n = 1'b1;
    i_cfg_ready = 1'b1;
    for (int b = 1; b <= 6; b++) push_word(b, 0);
    tick(7);
    check("rerun_level", 16'(o_state), 16'd1);
    check("rerun_drain", 16'(exp_q.size()), 16'd0);
    press(1, 0, 0);
    check("cleared_b1", o_gain, 16'd0);
    press(0, 1, 0);
    check("cleared_b2", o_gain, 16'd0);
    press(0, 1, 0);
    check("cleared_b3", o_gain, 16'd0);

    tick(2);
    check("final_drain", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
